// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package mc_ctrl_pkg;

  localparam int unsigned ALU_CODE_W = 4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT,
    ALUOP_PASSB
  } alu_op_t;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT   = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU  = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL   = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL   = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA   = 4'd9;
  localparam logic [ALU_CODE_W-1:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Branch condition from the flags of rs1 - rs2; Carry=1 means no borrow.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic negative, input logic carry,
                                        input logic overflow);
    logic lt;
    lt = negative ^ overflow;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      3'b110:  branch_taken = ~carry;
      3'b111:  branch_taken = carry;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: ALUOp plus instruction fields to ALU control code.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_PASSB: alu_control = ALU_PASSB;
      default: begin
        case (funct3)
          // op5 separates SUB from ADDI, whose imm[10] lands on funct7b5
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I controller: one registered FSM driving the shared-memory datapath.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W       = 4,
  parameter bit          MEM_WAIT_EN     = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Negative,
  input  logic                 Carry,
  input  logic                 Overflow,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 IllegalInstr
);

  state_t    state;
  state_t    state_nxt;
  alu_op_t   alu_op;
  logic      mem_ready_eff;
  logic      mem_req_s;
  logic      mem_write_s;
  logic      reg_write_s;
  logic      ir_write_s;
  logic      pc_write_s;
  logic [3:0] alu_code;

  assign mem_ready_eff = MEM_WAIT_EN ? MemReady : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next state and Moore decode; only PCWrite/IRWrite look at live inputs
  always_comb begin
    state_nxt    = state;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ImmSrc       = IMM_I;
    alu_op       = ALUOP_ADD;
    IllegalInstr = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req_s = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready_eff) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default:           state_nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = (op == OP_STORE) ? IMM_S : IMM_I;
        state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready_eff) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        AdrSrc      = 1'b1;
        if (mem_ready_eff) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        pc_write_s = branch_taken(funct3, Zero, Negative, Carry, Overflow);
        state_nxt  = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_JAL;
      end
      // PC takes ALUOut (target); ALU forms OldPC+4 for the link write
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write_s = 1'b1;
        state_nxt  = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_U;
        alu_op    = ALUOP_PASSB;
        state_nxt = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_U;
        state_nxt = S_ALUWB;
      end
      S_TRAP: begin
        IllegalInstr = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_code)
  );

  assign ALUControl = ALUCTRL_W'(alu_code);

  // Enables are held off for the whole reset pulse, abandoning any access
  assign MemReq   = mem_req_s   & ~reset;
  assign MemWrite = mem_write_s & ~reset;
  assign RegWrite = reg_write_s & ~reset;
  assign IRWrite  = ir_write_s  & ~reset;
  assign PCWrite  = pc_write_s  & ~reset;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed instruction table, corner sequences, random programs vs. a cycle-script model.
module tb_mc_ctrl_fsm;

  localparam int unsigned AW = 5;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_RT  = 7'b0110011;
  localparam logic [6:0] OP_IT  = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JL  = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LU  = 7'b0110111;
  localparam logic [6:0] OP_AU  = 7'b0010111;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic          Zero, Negative, Carry, Overflow;
  logic          MemReady;
  logic          MemReq, MemWrite, RegWrite, IRWrite, PCWrite, AdrSrc;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]    ImmSrc;
  logic [AW-1:0] ALUControl;
  logic          IllegalInstr;

  mc_ctrl_fsm #(.ALUCTRL_W(AW), .MEM_WAIT_EN(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .IllegalInstr(IllegalInstr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mem_req, mem_write, reg_write, ir_write, pc_write, adr_src, illegal;
    logic [1:0]    res, src_a, src_b;
    logic [2:0]    imm;
    logic [AW-1:0] alu;
  } ctl_t;

  typedef struct {
    logic mem;
    logic ready;
    ctl_t c;
  } step_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] fl;
    int         cycles;
    int         alu3;
    int         rw;
    int         pw;
  } vec_t;

  int    n_pass = 0;
  int    n_total = 0;
  step_t exp_q[$];
  vec_t  tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic ctl_t observe();
    ctl_t c;
    c.mem_req = MemReq; c.mem_write = MemWrite; c.reg_write = RegWrite;
    c.ir_write = IRWrite; c.pc_write = PCWrite; c.adr_src = AdrSrc;
    c.illegal = IllegalInstr; c.res = ResultSrc; c.src_a = ALUSrcA;
    c.src_b = ALUSrcB; c.imm = ImmSrc; c.alu = ALUControl;
    return c;
  endfunction

  function automatic ctl_t mk(input logic [1:0] a, input logic [1:0] b, input logic [1:0] r,
                              input logic [2:0] imm, input logic [3:0] alu);
    ctl_t c;
    c = '0;
    c.src_a = a; c.src_b = b; c.res = r; c.imm = imm; c.alu = AW'(alu);
    return c;
  endfunction

  // Instruction semantics: which ALU operation the instruction means
  function automatic logic [3:0] alu_fn(input logic is_r, input logic [2:0] f3, input logic f7);
    logic [3:0] base [8];
    base = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (f3 == 3'd0 && is_r && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd9;
    return base[f3];
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic [3:0] fl);
    logic z, n, c, v;
    {z, n, c, v} = fl;
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n != v;
      3'd5:    return n == v;
      3'd6:    return !c;
      3'd7:    return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void push(input logic mem, input logic rdy, input ctl_t c);
    step_t s;
    s.mem = mem; s.ready = rdy; s.c = c;
    exp_q.push_back(s);
  endfunction

  // Cycle script of one instruction: fetch with fw waits, decode, then class-specific work
  function automatic void build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic [3:0] fl, input int fw, input int mw);
    ctl_t c, wb, jl;
    exp_q.delete();
    wb = mk(2'd0, 2'd0, 2'd0, 3'd0, 4'd0); wb.reg_write = 1'b1;
    jl = mk(2'd1, 2'd2, 2'd0, 3'd0, 4'd0); jl.pc_write = 1'b1;
    c = mk(2'd0, 2'd2, 2'd2, 3'd0, 4'd0); c.mem_req = 1'b1;
    for (int i = 0; i < fw; i++) push(1'b1, 1'b0, c);
    c.ir_write = 1'b1; c.pc_write = 1'b1;
    push(1'b1, 1'b1, c);
    push(1'b0, 1'b0, mk(2'd1, 2'd1, 2'd0, (o == OP_JL) ? 3'd3 : 3'd2, 4'd0));
    case (o)
      OP_LD, OP_ST: begin
        push(1'b0, 1'b0, mk(2'd2, 2'd1, 2'd0, (o == OP_ST) ? 3'd1 : 3'd0, 4'd0));
        c = mk(2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
        c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = (o == OP_ST);
        for (int i = 0; i < mw; i++) push(1'b1, 1'b0, c);
        push(1'b1, 1'b1, c);
        if (o == OP_LD) begin
          c = mk(2'd0, 2'd0, 2'd1, 3'd0, 4'd0); c.reg_write = 1'b1;
          push(1'b0, 1'b0, c);
        end
      end
      OP_RT, OP_IT: begin
        push(1'b0, 1'b0, mk(2'd2, (o == OP_IT) ? 2'd1 : 2'd0, 2'd0, 3'd0,
                            alu_fn(o == OP_RT, f3, f7)));
        push(1'b0, 1'b0, wb);
      end
      OP_BR: begin
        c = mk(2'd2, 2'd0, 2'd0, 3'd0, 4'd1); c.pc_write = taken(f3, fl);
        push(1'b0, 1'b0, c);
      end
      OP_JR: begin
        push(1'b0, 1'b0, mk(2'd2, 2'd1, 2'd0, 3'd0, 4'd0));
        push(1'b0, 1'b0, jl); push(1'b0, 1'b0, wb);
      end
      OP_JL: begin
        push(1'b0, 1'b0, jl); push(1'b0, 1'b0, wb);
      end
      OP_LU: begin
        push(1'b0, 1'b0, mk(2'd0, 2'd1, 2'd0, 3'd4, 4'd10)); push(1'b0, 1'b0, wb);
      end
      OP_AU: begin
        push(1'b0, 1'b0, mk(2'd1, 2'd1, 2'd0, 3'd4, 4'd0)); push(1'b0, 1'b0, wb);
      end
      default: begin
        c = '0; c.illegal = 1'b1;
        push(1'b0, 1'b0, c);
      end
    endcase
  endfunction

  // Plays one instruction from its FETCH cycle; MemReady is random wherever no access is pending
  task automatic run_model(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [3:0] fl, input int fw, input int mw,
                           output int rw_cnt, output int mreq_cnt);
    build(o, f3, f7, fl, fw, mw);
    op = o; funct3 = f3; funct7b5 = f7; {Zero, Negative, Carry, Overflow} = fl;
    rw_cnt = 0; mreq_cnt = 0;
    foreach (exp_q[i]) begin
      MemReady = exp_q[i].mem ? exp_q[i].ready : 1'($urandom);
      #1;
      chk(tag, 64'(observe()), 64'(exp_q[i].c));
      rw_cnt += int'(RegWrite);
      mreq_cnt += int'(MemReq);
      @(negedge clk);
    end
  endtask

  // Zero-wait run from FETCH to the next FETCH, summarised into counts
  task automatic measure(input vec_t v);
    int cyc, rw, pw;
    logic [AW-1:0] alu3;
    cyc = -1; rw = 0; pw = 0; alu3 = '0;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; {Zero, Negative, Carry, Overflow} = v.fl;
    MemReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c > 0 && IRWrite) begin
        cyc = c;
        break;
      end
      rw += int'(RegWrite);
      pw += int'(PCWrite);
      if (c == 2) alu3 = ALUControl;
      @(negedge clk);
    end
    chk({v.name, "_cycles"}, 64'(cyc), 64'(v.cycles));
    chk({v.name, "_alu"}, 64'(alu3), 64'(v.alu3));
    chk({v.name, "_regwrite"}, 64'(rw), 64'(v.rw));
    chk({v.name, "_pcwrite"}, 64'(pw), 64'(v.pw));
  endtask

  task automatic add_vec(input string n, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [3:0] fl, input int cy,
                         input int alu, input int rw, input int pw);
    vec_t v;
    v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.fl = fl;
    v.cycles = cy; v.alu3 = alu; v.rw = rw; v.pw = pw;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    MemReady = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int rw, mq;
    logic [6:0] ops [9];
    ctl_t c;
    ops = '{OP_LD, OP_ST, OP_RT, OP_IT, OP_BR, OP_JL, OP_JR, OP_LU, OP_AU};

    // flags are {Zero, Negative, Carry, Overflow}
    add_vec("add",   OP_RT, 3'd0, 1'b0, 4'b0000, 4, 0, 1, 1);
    add_vec("sub",   OP_RT, 3'd0, 1'b1, 4'b0000, 4, 1, 1, 1);
    add_vec("sll",   OP_RT, 3'd1, 1'b0, 4'b0000, 4, 7, 1, 1);
    add_vec("slt",   OP_RT, 3'd2, 1'b0, 4'b0000, 4, 5, 1, 1);
    add_vec("sltu",  OP_RT, 3'd3, 1'b0, 4'b0000, 4, 6, 1, 1);
    add_vec("xor",   OP_RT, 3'd4, 1'b0, 4'b0000, 4, 4, 1, 1);
    add_vec("srl",   OP_RT, 3'd5, 1'b0, 4'b0000, 4, 8, 1, 1);
    add_vec("sra",   OP_RT, 3'd5, 1'b1, 4'b0000, 4, 9, 1, 1);
    add_vec("or",    OP_RT, 3'd6, 1'b0, 4'b0000, 4, 3, 1, 1);
    add_vec("and",   OP_RT, 3'd7, 1'b0, 4'b0000, 4, 2, 1, 1);
    add_vec("addi7", OP_IT, 3'd0, 1'b1, 4'b0000, 4, 0, 1, 1);
    add_vec("srai",  OP_IT, 3'd5, 1'b1, 4'b0000, 4, 9, 1, 1);
    add_vec("xori",  OP_IT, 3'd4, 1'b0, 4'b0000, 4, 4, 1, 1);
    add_vec("lw",    OP_LD, 3'd2, 1'b0, 4'b0000, 5, 0, 1, 1);
    add_vec("sw",    OP_ST, 3'd2, 1'b0, 4'b0000, 4, 0, 0, 1);
    add_vec("beq_t", OP_BR, 3'd0, 1'b0, 4'b1000, 3, 1, 0, 2);
    add_vec("bne_n", OP_BR, 3'd1, 1'b0, 4'b1000, 3, 1, 0, 1);
    add_vec("bltu_t", OP_BR, 3'd6, 1'b0, 4'b0000, 3, 1, 0, 2);
    add_vec("bltu_n", OP_BR, 3'd6, 1'b0, 4'b0010, 3, 1, 0, 1);
    add_vec("bge_t", OP_BR, 3'd5, 1'b0, 4'b0101, 3, 1, 0, 2);
    add_vec("blt_n", OP_BR, 3'd4, 1'b0, 4'b0101, 3, 1, 0, 1);
    add_vec("br010", OP_BR, 3'd2, 1'b0, 4'b1111, 3, 1, 0, 1);
    add_vec("jal",   OP_JL, 3'd0, 1'b0, 4'b0000, 4, 0, 1, 2);
    add_vec("jalr",  OP_JR, 3'd0, 1'b0, 4'b0000, 5, 0, 1, 2);
    add_vec("lui",   OP_LU, 3'd0, 1'b0, 4'b0000, 4, 10, 1, 1);
    add_vec("auipc", OP_AU, 3'd0, 1'b0, 4'b0000, 4, 0, 1, 1);

    reset = 1'b1; op = OP_IT; funct3 = '0; funct7b5 = 1'b0;
    {Zero, Negative, Carry, Overflow} = 4'b0000; MemReady = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 64'(observe()), 64'(mk(2'd0, 2'd2, 2'd2, 3'd0, 4'd0)));
    reset = 1'b0;
    #1;
    c = mk(2'd0, 2'd2, 2'd2, 3'd0, 4'd0);
    c.mem_req = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
    chk("release_fetch", 64'(observe()), 64'(c));

    foreach (tbl[i]) measure(tbl[i]);

    // Realign to a clean FETCH before the model-driven sequences
    do_reset();

    run_model("lw_wait", OP_LD, 3'd2, 1'b0, 4'b0000, 0, 3, rw, mq);
    chk("lw_wait_regwrite", 64'(rw), 64'd1);
    chk("lw_wait_memread_req", 64'(mq - 1), 64'd4);
    run_model("sw_wait", OP_ST, 3'd2, 1'b0, 4'b0000, 2, 2, rw, mq);
    chk("sw_wait_regwrite", 64'(rw), 64'd0);

    for (int n = 0; n < 150; n++) begin
      run_model("rand", ops[$urandom_range(0, 8)], 3'($urandom), 1'($urandom),
                4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rw, mq);
    end

    // Illegal opcode parks the controller until reset
    run_model("illegal", 7'b0000000, 3'd0, 1'b0, 4'b0000, 0, 0, rw, mq);
    c = '0; c.illegal = 1'b1;
    for (int n = 0; n < 5; n++) begin
      op = ops[$urandom_range(0, 8)];
      MemReady = 1'($urandom);
      #1;
      chk("trap_hold", 64'(observe()), 64'(c));
      @(negedge clk);
    end
    do_reset();

    // Reset in the middle of a stalled store drops MemWrite at once
    op = OP_ST; funct3 = 3'd2; MemReady = 1'b1;
    repeat (3) @(negedge clk);
    MemReady = 1'b0;
    #1;
    chk("sw_before_reset", 64'({MemReq, MemWrite}), 64'b11);
    reset = 1'b1;
    #1;
    chk("sw_reset_abandon", 64'({MemReq, MemWrite, IllegalInstr}), 64'b000);
    @(negedge clk);
    reset = 1'b0;
    run_model("post_reset", OP_LU, 3'd0, 1'b0, 4'b0000, 1, 0, rw, mq);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
